// File: rtl/conv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : conv_requant
//  Description : Requantization of signed convolution accumulators into
//                saturated signed activations. Three-stage valid/ready
//                pipeline (bias add, fixed-point multiply, round/shift/
//                zero-point/clamp). A new quantization set is held in a
//                shadow copy and becomes active only once the pipeline is
//                empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_requant #(
    parameter int ACC_WIDTH = 32,
    parameter int C_WIDTH   = 16,
    parameter int M0_WIDTH  = 32,
    parameter int N_WIDTH   = 8,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enb_cfg,
    input  logic [C_WIDTH-1:0]   i_C,
    input  logic [M0_WIDTH-1:0]  i_M0,
    input  logic [N_WIDTH-1:0]   i_N,
    input  logic [OUT_WIDTH-1:0] i_Z,
    input  logic                 i_valid,
    input  logic [ACC_WIDTH-1:0] i_acc,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_sat,
    input  logic                 i_ready,
    output logic                 o_cfg_busy
);

    localparam int c_SUM_W  = ACC_WIDTH + 1;
    localparam int c_PROD_W = ACC_WIDTH + M0_WIDTH + 1;
    // One spare bit so adding the rounding constant can never wrap.
    localparam int c_RND_W  = c_PROD_W + 1;
    localparam int c_SH_W   = $clog2(M0_WIDTH + 32) + 1;

    localparam logic [N_WIDTH-1:0]        c_N_MAX   = N_WIDTH'(31);
    localparam logic signed [c_RND_W-1:0] c_OUT_MAX =
        (c_RND_W'(1) << (OUT_WIDTH - 1)) - c_RND_W'(1);
    localparam logic signed [c_RND_W-1:0] c_OUT_MIN = ~c_OUT_MAX;

    // Active and shadow quantization sets
    logic [C_WIDTH-1:0]   r_c,  r_c_sh;
    logic [M0_WIDTH-1:0]  r_m0, r_m0_sh;
    logic [N_WIDTH-1:0]   r_n,  r_n_sh;
    logic [OUT_WIDTH-1:0] r_z,  r_z_sh;
    logic                 r_cfg_pending;

    // Pipeline state
    logic                      r_s1_valid;
    logic [c_SUM_W-1:0]        r_s1_sum;
    logic                      r_s2_valid;
    logic signed [c_PROD_W-1:0] r_s2_prod;
    logic                      r_s3_valid;

    // Handshake wires
    logic w_s3_load, w_s2_adv, w_s2_load, w_s1_adv, w_s1_load;
    logic w_in_fire, w_empty, w_apply;

    // Datapath wires
    logic [c_SUM_W-1:0]          w_acc_x, w_c_x, w_sum;
    logic signed [c_PROD_W-1:0]  w_sum_x, w_m0_x, w_prod;
    logic [c_SH_W-1:0]           w_n_clip, w_sh;
    logic signed [c_RND_W-1:0]   w_prod_x, w_half, w_rnd, w_shr, w_z_x, w_v;
    logic [OUT_WIDTH-1:0]        w_out;
    logic                        w_sat;

    // Backpressure chain: a stage may load when it is empty or draining.
    always_comb begin
        w_s3_load = !r_s3_valid || i_ready;
        w_s2_adv  = r_s2_valid && w_s3_load;
        w_s2_load = !r_s2_valid || w_s2_adv;
        w_s1_adv  = r_s1_valid && w_s2_load;
        w_s1_load = !r_s1_valid || w_s1_adv;
        o_ready   = !r_cfg_pending && w_s1_load;
        w_in_fire = i_valid && o_ready;
        w_empty   = !r_s1_valid && !r_s2_valid && !r_s3_valid;
        w_apply   = r_cfg_pending && w_empty;
    end

    assign o_valid    = r_s3_valid;
    assign o_cfg_busy = r_cfg_pending;

    // Stage 1 bias add and stage 2 multiply, both at full precision.
    always_comb begin
        w_acc_x  = {{(c_SUM_W - ACC_WIDTH){i_acc[ACC_WIDTH-1]}}, i_acc};
        w_c_x    = {{(c_SUM_W - C_WIDTH){r_c[C_WIDTH-1]}}, r_c};
        w_sum    = w_acc_x + w_c_x;
        w_sum_x  = {{(c_PROD_W - c_SUM_W){r_s1_sum[c_SUM_W-1]}}, r_s1_sum};
        w_m0_x   = {{(c_PROD_W - M0_WIDTH){r_m0[M0_WIDTH-1]}}, r_m0};
        w_prod   = w_sum_x * w_m0_x;
    end

    // Stage 3: round half toward +inf, arithmetic shift, zero point, clamp.
    always_comb begin
        w_n_clip = (r_n > c_N_MAX) ? c_SH_W'(31) : c_SH_W'(r_n);
        w_sh     = c_SH_W'(M0_WIDTH - 1) + w_n_clip;
        w_prod_x = {r_s2_prod[c_PROD_W-1], r_s2_prod};
        // (1 << sh) >> 1 gives 2^(sh-1), and zero when sh is zero.
        w_half   = (c_RND_W'(1) << w_sh) >> 1;
        w_rnd    = w_prod_x + w_half;
        w_shr    = w_rnd >>> w_sh;
        w_z_x    = {{(c_RND_W - OUT_WIDTH){r_z[OUT_WIDTH-1]}}, r_z};
        w_v      = w_shr + w_z_x;
        w_out    = w_v[OUT_WIDTH-1:0];
        w_sat    = 1'b0;
        if (w_v > c_OUT_MAX) begin
            w_out = c_OUT_MAX[OUT_WIDTH-1:0];
            w_sat = 1'b1;
        end else if (w_v < c_OUT_MIN) begin
            w_out = c_OUT_MIN[OUT_WIDTH-1:0];
            w_sat = 1'b1;
        end
    end

    // Shadow capture and swap into the active set once the pipeline drains.
    // A load request on the swap edge keeps the pending flag set so the
    // newest shadow copy is applied on the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_pending <= 1'b0;
            r_c_sh  <= '0;
            r_m0_sh <= '0;
            r_n_sh  <= '0;
            r_z_sh  <= '0;
            r_c     <= '0;
            r_m0    <= '0;
            r_n     <= '0;
            r_z     <= '0;
        end else begin
            if (i_enb_cfg) begin
                r_c_sh        <= i_C;
                r_m0_sh       <= i_M0;
                r_n_sh        <= i_N;
                r_z_sh        <= i_Z;
                r_cfg_pending <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pending <= 1'b0;
            end
            if (w_apply) begin
                r_c  <= r_c_sh;
                r_m0 <= r_m0_sh;
                r_n  <= r_n_sh;
                r_z  <= r_z_sh;
            end
        end
    end

    // Stage 1 register: biased accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_sum <= w_sum;
            end
        end
    end

    // Stage 2 register: scaled product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod <= w_prod;
            end
        end
    end

    // Stage 3 register: output word, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            o_data     <= '0;
            o_sat      <= 1'b0;
        end else if (w_s3_load) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                o_data <= w_out;
                o_sat  <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_requant
//  Description : Self-checking bench for conv_requant with a wide-integer
//                reference model and an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enb_cfg;
    logic [15:0] i_C;
    logic [31:0] i_M0;
    logic [7:0]  i_N;
    logic [7:0]  i_Z;
    logic        i_valid;
    logic [31:0] i_acc;
    logic        o_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_sat;
    logic        i_ready;
    logic        o_cfg_busy;

    conv_requant dut (
        .clk        (clk),
        .rst        (rst),
        .i_enb_cfg  (i_enb_cfg),
        .i_C        (i_C),
        .i_M0       (i_M0),
        .i_N        (i_N),
        .i_Z        (i_Z),
        .i_valid    (i_valid),
        .i_acc      (i_acc),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_sat      (o_sat),
        .i_ready    (i_ready),
        .o_cfg_busy (o_cfg_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit s;
        int c;
    } exp_t;

    exp_t   exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     n_out = 0;
    bit     lat_chk = 1'b0;
    bit     in_fire, out_fire;

    // Model view of the quantization set that applies to new accepts
    longint m_c, m_m0, m_n, m_z;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference requantization in 128-bit integer arithmetic
    function automatic exp_t model(input longint acc);
        logic signed [127:0] sum, prod, r, v;
        int   sh;
        exp_t e;
        sum  = acc + m_c;
        prod = sum * m_m0;
        sh   = 31 + ((m_n > 31) ? 31 : int'(m_n));
        r    = (prod + (128'sd1 <<< (sh - 1))) >>> sh;
        v    = r + m_z;
        e.c  = cyc;
        if (v > 127)       begin e.d = 127;    e.s = 1'b1; end
        else if (v < -128) begin e.d = -128;   e.s = 1'b1; end
        else               begin e.d = int'(v); e.s = 1'b0; end
        return e;
    endfunction

    // One clock: observe handshakes mid-cycle, then advance past the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        in_fire  = i_valid && o_ready;
        out_fire = o_valid && i_ready;
        if (o_cfg_busy) chk("busy_blocks_ready", longint'(o_ready), 0);
        if (out_fire) begin
            n_out++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", longint'(o_valid), 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", longint'($signed(o_data)), e.d);
                chk("sat", longint'(o_sat), longint'(e.s));
                if (lat_chk) chk("latency", cyc - e.c, 3);
            end
        end
        if (in_fire) exp_q.push_back(model(longint'($signed(i_acc))));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int k;
        i_valid = 1'b0;
        i_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || o_valid) && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Pulse a new set, then wait (bounded) for it to become active.
    task automatic set_cfg(input longint c, input longint m0, input longint n, input longint z);
        int k;
        i_enb_cfg = 1'b1;
        i_C  = 16'(c);
        i_M0 = 32'(m0);
        i_N  = 8'(n);
        i_Z  = 8'(z);
        tick();
        i_enb_cfg = 1'b0;
        m_c = c; m_m0 = m0; m_n = n; m_z = z;
        k = 0;
        while (o_cfg_busy && k < 60) begin
            tick();
            k++;
        end
        if (k >= 60) chk("cfg_timeout", longint'(o_cfg_busy), 0);
    endtask

    task automatic send(input longint acc);
        int k;
        i_valid = 1'b1;
        i_acc   = 32'(acc);
        k = 0;
        do begin
            tick();
            k++;
        end while (!in_fire && k < 60);
        if (!in_fire) chk("send_timeout", longint'(in_fire), 1);
        i_valid = 1'b0;
    endtask

    initial begin : main
        longint hold_acc[6];
        int     idx, k, out0;

        rst = 1'b1; i_enb_cfg = 1'b0; i_C = '0; i_M0 = '0; i_N = '0; i_Z = '0;
        i_valid = 1'b0; i_acc = '0; i_ready = 1'b1;
        m_c = 0; m_m0 = 0; m_n = 0; m_z = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", longint'(o_valid), 0);
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_o_sat", longint'(o_sat), 0);
        chk("rst_cfg_busy", longint'(o_cfg_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_o_ready", longint'(o_ready), 1);

        // Basic scaling by 0.5 with rounding and latency
        set_cfg(0, 64'h4000_0000, 0, 0);
        lat_chk = 1'b1;
        i_valid = 1'b1;
        foreach (hold_acc[j]) hold_acc[j] = 0;
        i_acc = 32'd100;              tick();
        i_acc = 32'd101;              tick();
        i_acc = 32'(-101);            tick();
        drain();
        lat_chk = 1'b0;

        // Saturation at both rails
        send(1000);
        send(-1000);
        drain();

        // Bias, extra shift and zero point: (44-4)*0.5 = 20, >>2 = 5, +10 = 15
        set_cfg(-4, 64'h4000_0000, 2, 10);
        send(44);
        drain();

        // Backpressure: exactly three accepted while the consumer stalls
        set_cfg(0, 64'h4000_0000, 0, 0);
        for (int j = 0; j < 6; j++) hold_acc[j] = longint'($signed(32'($urandom_range(0, 400)))) - 200;
        out0 = n_out;
        idx = 0;
        i_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            i_valid = (idx < 6);
            i_acc   = 32'(hold_acc[idx]);
            tick();
            if (in_fire) idx++;
        end
        chk("hold_accepts", idx, 3);
        chk("hold_ready_low", longint'(o_ready), 0);
        chk("hold_valid_high", longint'(o_valid), 1);
        i_ready = 1'b1;
        k = 0;
        while (idx < 6 && k < 60) begin
            i_valid = 1'b1;
            i_acc   = 32'(hold_acc[idx]);
            tick();
            if (in_fire) idx++;
            k++;
        end
        chk("hold_all_accepted", idx, 6);
        drain();
        chk("hold_out_count", n_out - out0, 6);

        // Config change with three results in flight (0.5 -> 0.25)
        i_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(400 + 4 * j);
        i_enb_cfg = 1'b1; i_C = '0; i_M0 = 32'h2000_0000; i_N = '0; i_Z = '0;
        tick();
        i_enb_cfg = 1'b0;
        m_m0 = 64'h2000_0000;
        chk("inflight_busy", longint'(o_cfg_busy), 1);
        chk("inflight_ready", longint'(o_ready), 0);
        repeat (3) tick();
        chk("inflight_busy_held", longint'(o_cfg_busy), 1);
        i_ready = 1'b1;
        for (int j = 0; j < 3; j++) send(400 + 4 * j);
        drain();

        // Simultaneous accept and config pulse: input uses the old set
        i_valid = 1'b1; i_acc = 32'd200;
        i_enb_cfg = 1'b1; i_C = 16'd6; i_M0 = 32'h6000_0000; i_N = 8'd1; i_Z = 8'(-3);
        tick();
        chk("simul_accept", longint'(in_fire), 1);
        i_valid = 1'b0; i_enb_cfg = 1'b0;
        m_c = 6; m_m0 = 64'h6000_0000; m_n = 1; m_z = -3;
        send(-77);
        drain();

        // Randomized traffic with occasional configuration changes
        for (int j = 0; j < 400; j++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_acc   = $urandom;
            if ($urandom_range(0, 1) == 0) i_acc = 32'($signed(i_acc) >>> $urandom_range(8, 24));
            i_enb_cfg = ($urandom_range(0, 39) == 0);
            i_C  = 16'($urandom);
            i_M0 = 32'($urandom);
            i_N  = (j == 200) ? 8'd200 : 8'($urandom_range(0, 40));
            i_Z  = 8'($urandom);
            tick();
            if (i_enb_cfg) begin
                m_c  = longint'($signed(i_C));
                m_m0 = longint'($signed(i_M0));
                m_n  = longint'(i_N);
                m_z  = longint'($signed(i_Z));
            end
        end
        i_enb_cfg = 1'b0;
        drain();
        k = 0;
        while (o_cfg_busy && k < 20) begin tick(); k++; end

        // Reset with two items in flight and a config pending
        set_cfg(0, 64'h4000_0000, 0, 0);
        i_ready = 1'b0;
        send(10);
        send(20);
        i_enb_cfg = 1'b1; i_M0 = 32'h7000_0000;
        tick();
        i_enb_cfg = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_o_valid", longint'(o_valid), 0);
        chk("rst_mid_cfg_busy", longint'(o_cfg_busy), 0);
        exp_q.delete();
        m_c = 0; m_m0 = 0; m_n = 0; m_z = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", longint'(o_ready), 1);
        i_ready = 1'b1;
        send(1000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
